// File: rtl/data_mem_port.sv
// data_mem_port: load/store unit bridging the core to a word-wide memory backend with
// byte lanes, alignment checking, load extension and a bounded wait for acknowledge.
module data_mem_port #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemEna,
    input  logic [1:0]  MemRW,
    input  logic [2:0]  SWSel,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic [31:0] RData,
    output logic        Stall,
    output logic        MisAlign,
    output logic        AccErr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    lo_q;
    logic [2:0]    sel_q;
    logic          mis, start, acked, tout;
    logic [3:0]    be;
    logic [31:0]   wd, ld;
    logic [7:0]    b;
    logic [15:0]   h;

    always_comb begin
        mis = MemRW == 2'b01 ? 1'b0 :
              MemRW == 2'b10 ? Addr[0] :
              MemRW == 2'b11 ? |Addr[1:0] :
              (SWSel == 3'b000 || SWSel == 3'b011) ? 1'b0 :
              (SWSel == 3'b001 || SWSel == 3'b100) ? Addr[0] : |Addr[1:0];
        be = MemRW == 2'b01 ? 4'b0001 << Addr[1:0] :
             MemRW == 2'b10 ? 4'b0011 << {Addr[1], 1'b0} : 4'b1111;
        wd = MemRW == 2'b01 ? {4{WData[7:0]}} :
             MemRW == 2'b10 ? {2{WData[15:0]}} : WData;
        // lane selection uses the offset latched at request time, not the live Addr
        b  = 8'(mem_rdata >> {lo_q, 3'b000});
        h  = 16'(mem_rdata >> {lo_q[1], 4'b0000});
        ld = sel_q == 3'b000 ? {24'b0, b} :
             sel_q == 3'b001 ? {16'b0, h} :
             sel_q == 3'b011 ? {{24{b[7]}}, b} :
             sel_q == 3'b100 ? {{16{h[15]}}, h} : mem_rdata;
        start = state_q == IDLE && MemEna && !mis;
        acked = state_q == BUSY && mem_ack;
        tout  = state_q == BUSY && !mem_ack && cnt_q == CW'(TIMEOUT - 1);
        state_d = state_q == IDLE ? (MemEna ? (mis ? DONE : BUSY) : IDLE) :
                  state_q == BUSY ? ((mem_ack || tout) ? DONE : BUSY) : IDLE;
        cnt_d = state_q == BUSY ? cnt_q + 1'b1 : '0;
    end

    assign Stall = MemEna && state_q != DONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lo_q      <= '0;
            sel_q     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            RData     <= '0;
            MisAlign  <= 1'b0;
            AccErr    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mem_req  <= state_d == BUSY;
            MisAlign <= state_q == IDLE && MemEna && mis;
            AccErr   <= tout;
            if (start) begin
                mem_we    <= |MemRW;
                mem_be    <= be;
                mem_addr  <= Addr[31:2];
                mem_wdata <= wd;
                lo_q      <= Addr[1:0];
                sel_q     <= SWSel;
            end
            if (state_d == DONE)
                RData <= (acked && !mem_we) ? ld : '0;
        end
    end
endmodule

// File: tb/tb_data_mem_port.sv
// tb_data_mem_port: directed and random load/store transactions checked against
// an access-size based reference model.
module tb_data_mem_port;
    localparam int TO = 15;

    logic        clk, reset, MemEna;
    logic [1:0]  MemRW;
    logic [2:0]  SWSel;
    logic [31:0] Addr, WData, RData, mem_wdata, mem_rdata;
    logic        Stall, MisAlign, AccErr, mem_req, mem_we, mem_ack;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    int          total = 0;
    int          bad = 0;

    data_mem_port #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .MemEna(MemEna), .MemRW(MemRW), .SWSel(SWSel),
        .Addr(Addr), .WData(WData), .RData(RData), .Stall(Stall), .MisAlign(MisAlign),
        .AccErr(AccErr), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Access size in bytes: stores by MemRW, loads by SWSel (unknown codes act as words).
    function automatic int acc_size(input logic [1:0] rw, input logic [2:0] sel);
        if (rw != 0) return rw == 1 ? 1 : rw == 2 ? 2 : 4;
        return (sel == 0 || sel == 3) ? 1 : (sel == 1 || sel == 4) ? 2 : 4;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] sel, input logic [31:0] addr,
                                             input logic [31:0] rd);
        int     sz  = acc_size(2'b00, sel);
        int     off = addr % 4;
        longint v;
        int     sh  = sz == 1 ? 8 * off : sz == 2 ? 8 * (off / 2 * 2) : 0;
        v = (longint'(rd) >> sh) & ((64'd1 << (8 * sz)) - 1);
        if ((sel == 3 || sel == 4) && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
        return 32'(v);
    endfunction

    task automatic txn(input logic [1:0] rw, input logic [2:0] sel, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input int dly, input bit drop, input bit chain);
        int          sz = acc_size(rw, sel);
        bit          mis = (addr % sz) != 0;
        logic [3:0]  ebe;
        logic [31:0] ewd, erd;
        ebe = rw == 0 ? 4'hF : sz == 1 ? 4'(1 << (addr % 4)) : sz == 2 ? ((addr % 4) >= 2 ? 4'hC : 4'h3) : 4'hF;
        ewd = rw == 1 ? wdata[7:0] * 32'h0101_0101 : rw == 2 ? wdata[15:0] * 32'h0001_0001 : wdata;
        erd = (rw != 0 || dly >= TO) ? 32'h0 : load_val(sel, addr, rdata);
        MemEna = 1'b1; MemRW = rw; SWSel = sel; Addr = addr; WData = wdata; mem_ack = 1'b0;
        #1 chk("stall_idle", Stall, 1);
        if (mis) begin
            @(negedge clk);
            chk("misalign_pulse", MisAlign, 1);
            chk("misalign_accerr", AccErr, 0);
            chk("misalign_rdata", RData, 0);
            chk("misalign_req", mem_req, 0);
            chk("misalign_stall", Stall, 0);
        end else begin
            for (int i = 0; i < TO; i++) begin
                @(negedge clk);
                if (drop && i == 0) MemEna = 1'b0;
                #1;
                chk("busy_req", mem_req, 1);
                chk("busy_we", mem_we, rw != 0);
                chk("busy_be", mem_be, ebe);
                chk("busy_addr", {2'b0, mem_addr}, addr >> 2);
                chk("busy_wdata", mem_wdata, ewd);
                chk("busy_stall", Stall, MemEna);
                mem_ack = i == dly;
                mem_rdata = i == dly ? rdata : $urandom;
                if (i == dly) break;
            end
            @(negedge clk);
            mem_ack = 1'b0;
            chk("done_rdata", RData, erd);
            chk("done_accerr", AccErr, dly >= TO);
            chk("done_misalign", MisAlign, 0);
            chk("done_req", mem_req, 0);
            chk("done_stall", Stall, 0);
        end
        if (chain) begin
            @(negedge clk);
        end else begin
            MemEna = 1'b0;
            mem_ack = 1'($urandom % 2);
            @(negedge clk);
            #1;
            chk("idle_req", mem_req, 0);
            chk("idle_misalign", MisAlign, 0);
            chk("idle_accerr", AccErr, 0);
            chk("idle_stall", Stall, 0);
            mem_ack = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; MemEna = 1'b0; MemRW = 2'b00; SWSel = 3'b000; Addr = '0; WData = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_addr", {2'b0, mem_addr}, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", RData, 0);
        chk("rst_misalign", MisAlign, 0);
        chk("rst_accerr", AccErr, 0);
        chk("rst_stall_off", Stall, 0);
        MemEna = 1'b1;
        #1 chk("rst_stall_on", Stall, 1);
        MemEna = 1'b0; reset = 1'b0;
        @(negedge clk);
        txn(2'b00, 3'b011, 32'h1000_0003, 32'h0, 32'h8011_2233, 0, 0, 0);
        txn(2'b10, 3'b000, 32'h1000_0002, 32'h0000_BEEF, 32'h0, 0, 0, 0);
        txn(2'b00, 3'b010, 32'h1000_0001, 32'h0, 32'h0, 0, 0, 0);
        txn(2'b00, 3'b001, 32'h1000_0000, 32'h0, 32'hCAFE_F00D, TO, 0, 0);
        txn(2'b00, 3'b001, 32'h1000_0000, 32'h0, 32'hCAFE_F00D, TO - 1, 0, 0);
        txn(2'b00, 3'b000, 32'h1000_0001, 32'h0, 32'h1234_5678, 1, 0, 1);
        txn(2'b01, 3'b111, 32'h1000_0002, 32'h0000_00A5, 32'h0, 2, 0, 0);
        // reset while a store waits in BUSY; a late ack must not produce DONE
        MemEna = 1'b1; MemRW = 2'b11; SWSel = 3'b000; Addr = 32'h2000_0010; WData = 32'h1357_9BDF;
        @(negedge clk);
        chk("rstbusy_req", mem_req, 1);
        reset = 1'b1; MemEna = 1'b0;
        @(negedge clk);
        chk("rstbusy_req_drop", mem_req, 0);
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("late_ack_req", mem_req, 0);
        chk("late_ack_misalign", MisAlign, 0);
        chk("late_ack_accerr", AccErr, 0);
        chk("late_ack_rdata", RData, 0);
        mem_ack = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 80; n++) begin
            int d = ($urandom % 8 == 0) ? int'($urandom_range(TO - 2, TO + 1)) : int'($urandom % 4);
            txn(2'($urandom), 3'($urandom), $urandom, $urandom, $urandom, d,
                1'($urandom % 4 == 0), 1'($urandom % 3 == 0));
        end
        MemEna = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_mem_port.md
DATA_MEM_PORT -- requirements
Module: data_mem_port

Interface
REQ-001 Parameter: TIMEOUT, default 15, maximum cycles in BUSY awaiting mem_ack before abort.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  reset is synchronous and active-high.
REQ-004 MemEna  in  1  data-memory access requested by control decode (loads and stores).
REQ-005 MemRW  in  2  store width: 00 no store (load), 01 SB, 10 SH, 11 SW.
REQ-006 SWSel  in  3  load extension: 000 LBU, 001 LHU, 010 LW, 011 LB, 100 LH; 101-111 handled as LW.
REQ-007 Addr  in  32  byte address from ALU; WData  in  32  store data (rs2).
REQ-008 RData  out  32  aligned, extended load result; valid in DONE.
REQ-009 Stall  out  1  freeze PC/register writeback while high.
REQ-010 MisAlign  out  1  one-cycle pulse in DONE for misaligned access; AccErr  out  1  one-cycle pulse in DONE on timeout.
REQ-011 mem_req/mem_we  out  1 each; mem_be  out  4; mem_addr  out  30 (word address, Addr[31:2]); mem_wdata  out  32; all registered.
REQ-012 mem_ack  in  1  backend completion; mem_rdata  in  32  word read data, valid with mem_ack.

Function
REQ-013 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-014 IDLE: MemEna=0 -> stay IDLE; MemEna=1 and aligned -> latch request, go BUSY; MemEna=1 and misaligned -> go DONE with MisAlign flag set, no backend request.
REQ-015 Misaligned: SH/LH/LHU with Addr[0]=1; SW/LW (incl. SWSel 101-111) with Addr[1:0]!=00; byte accesses never misaligned.
REQ-016 MemRW!=00 selects a store regardless of SWSel; MemRW=00 selects a load.
REQ-017 BUSY: mem_req=1 with mem_we, mem_be, mem_addr, mem_wdata held constant; on mem_ack=1 capture load result, go DONE.
REQ-018 BUSY timeout counter clears on entering BUSY, increments each BUSY cycle without ack; reaching TIMEOUT without ack -> drop mem_req, go DONE with AccErr set, RData=0.
REQ-019 mem_ack and TIMEOUT in the same cycle: ack wins, no AccErr.
REQ-020 DONE: lasts exactly one cycle, then IDLE; mem_req=0.
REQ-021 Stall = MemEna and state in {IDLE, BUSY}; Stall=0 in DONE and whenever MemEna=0.
REQ-022 Minimum aligned access: 3 cycles (IDLE, BUSY with ack, DONE); misaligned: 2 cycles.
REQ-023 Byte enables: SB 4'b0001<<Addr[1:0]; SH 4'b0011<<{Addr[1],1'b0}; SW 4'b1111; loads 4'b1111, mem_we=0.
REQ-024 mem_wdata: SB WData[7:0] replicated x4; SH WData[15:0] replicated x2; SW WData.
REQ-025 Load extraction: byte lane mem_rdata>>(8*Addr[1:0]); half lane mem_rdata>>(16*Addr[1]); LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
REQ-026 RData registered on ack, held through DONE; 0 for stores, misaligned, timeout.
REQ-027 mem_ack outside BUSY ignored, no state or output change.
REQ-028 MemEna dropping while BUSY does not cancel; transaction completes to DONE.

Reset
REQ-029 On reset edge: state IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, RData=0, MisAlign=0, AccErr=0, counter=0; Stall follows REQ-021.
REQ-030 Reset mid-BUSY abandons transaction; mem_req low from next cycle; late ack ignored.

Verification
REQ-031 LB Addr=0x...0003, SWSel=011, ack next cycle with mem_rdata=0x80112233 -> RData=0xFFFFFF80 in DONE, Stall high 2 cycles then low.
REQ-032 SH Addr=0x...0002, WData=0x0000BEEF -> mem_be=1100, mem_wdata=0xBEEFBEEF, mem_we=1, RData=0.
REQ-033 LW Addr=0x...0001 -> no mem_req, DONE next cycle, MisAlign pulse 1 cycle, RData=0.
REQ-034 LHU Addr=0x...0000, no ack for TIMEOUT=15 cycles -> AccErr pulse, RData=0, mem_req drops; ack on cycle 15 exactly -> no AccErr, data returned.
REQ-035 SW in BUSY, reset asserted -> next cycle IDLE, mem_req=0; subsequent mem_ack produces no DONE.
REQ-036 Back-to-back LBU 0x...0001 then SB 0x...0002 with MemEna held -> second request enters BUSY directly after DONE->IDLE, mem_be=0100.
